// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// RV32I load/store funct3 codes, FSM states and byte-enable patterns.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_B0  = 4'b0001;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsu_state_e;

  // Stores only have byte/half/word; loads add the unsigned byte/half.
  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (st && f3[2]);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half lane of the read word
// and sign- or zero-extends it into the register write value.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_wd
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_wd   = '0;
    case (i_funct3)
      F3_LB:   o_wd = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_wd = {{16{w_half[15]}}, w_half};
      F3_LW:   o_wd = i_rdata;
      F3_LBU:  o_wd = {24'd0, w_byte};
      F3_LHU:  o_wd = {16'd0, w_half};
      default: o_wd = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with req/ack memory port and RF write-back.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses (adds port misaligned).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_a3,
  output logic [DATA_WIDTH-1:0] rf_wd3
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  misaligned
`endif
);

  lsu_state_e            r_state;
  logic                  r_store;
  logic [2:0]            r_f3;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_cnt;
  logic                  r_done;
  logic                  r_err;
  logic                  r_rf_we;
  logic [ADDR_WIDTH-1:0] r_rf_a3;
  logic [DATA_WIDTH-1:0] r_rf_wd3;

  logic                  w_illegal;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld;

  assign w_illegal = f3_illegal(is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = !w_illegal &&
    ((funct3[1:0] == 2'b01 && addr[0]) ||
     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));
  assign misaligned = r_mis;
`else
  assign w_mis = 1'b0;
`endif

  // Store lanes: data is replicated so any enabled lane sees it.
  always_comb begin
    w_be    = BE_ALL;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = BE_B0 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? BE_HI : BE_LO;
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_align (
    .i_rdata  (mem_rdata),
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .o_wd     (w_ld)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= IDLE;
      r_store  <= 1'b0;
      r_f3     <= '0;
      r_lane   <= '0;
      r_rd     <= '0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rf_we  <= 1'b0;
      r_rf_a3  <= '0;
      r_rf_wd3 <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis    <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rf_we <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
      unique case (r_state)
        IDLE: if (start) begin
          r_store <= is_store;
          r_f3    <= funct3;
          r_lane  <= addr[1:0];
          r_rd    <= rd;
          r_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
          r_be    <= w_be;
          r_wdata <= w_wdata;
          r_cnt   <= '0;
          if (w_illegal || w_mis) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            r_mis  <= w_mis;
`endif
          end else begin
            r_state <= REQ;
          end
        end
        REQ: if (mem_ack) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          if (r_store) begin
            r_state <= IDLE;
          end else begin
            r_state  <= WB;
            r_rf_we  <= (r_rd != '0);
            r_rf_a3  <= r_rd;
            r_rf_wd3 <= w_ld;
          end
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          r_cnt   <= '0;
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req && r_store;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign done      = r_done;
  assign err       = r_err;
  assign rf_we     = r_rf_we;
  assign rf_a3     = r_rf_a3;
  assign rf_wd3    = r_rf_wd3;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus
// randomized transactions checked against a transaction-level model.
module tb_load_store_unit;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, err, mem_req, mem_we, rf_we;
  logic [31:0] mem_addr, mem_wdata, rf_wd3;
  logic [3:0]  mem_be;
  logic [4:0]  rf_a3;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;
  int reqcnt = 0;
  bit en = 0;

  bit          e_done, e_err, e_req, e_rfwe, e_bchk, e_busy, e_zero, e_mis;
  logic        e_we;
  logic [31:0] e_maddr, e_wdata, e_wd3;
  logic [3:0]  e_be;
  logic [4:0]  e_a3;
  logic [31:0] cap_wd3, cap_wdata;
  logic [3:0]  cap_be;

  always #5 CLK = ~CLK;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst), .start(start), .is_store(is_store),
    .funct3(funct3), .rd(rd), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Reference model: results from the instruction-set rules
  function automatic bit illegal(bit st, logic [2:0] f);
    return f == 3'b011 || f == 3'b110 || f == 3'b111 || (st && f > 3'b010);
  endfunction

  function automatic bit misal(logic [2:0] f, logic [1:0] a);
    return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [31:0] ld_val(logic [2:0] f, logic [1:0] a,
                                         logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] st_be(logic [2:0] f, logic [1:0] a);
    if (f == 3'b000) return 4'(1 << a);
    if (f == 3'b001) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] st_wd(logic [2:0] f, logic [31:0] d);
    if (f == 3'b000) return d[7:0] * 32'h01010101;
    if (f == 3'b001) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  always @(negedge CLK) if (en) begin
    if (e_zero)
      chk("reset_zero", |{busy, done, err, mem_req, mem_we, mem_addr,
                          mem_be, mem_wdata, rf_we, rf_a3, rf_wd3}, 0);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("mem_req", mem_req, e_req);
    chk("rf_we", rf_we, e_rfwe);
    if (e_bchk) chk("busy", busy, e_busy);
    if (mem_req) reqcnt++;
    if (e_req) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_maddr);
      if (e_we) begin
        chk("mem_be", mem_be, e_be);
        chk("mem_wdata", mem_wdata, e_wdata);
        cap_be = mem_be;
        cap_wdata = mem_wdata;
      end
    end
    if (e_rfwe) begin
      chk("rf_a3", rf_a3, e_a3);
      chk("rf_wd3", rf_wd3, e_wd3);
      cap_wd3 = rf_wd3;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    chk("misaligned", misaligned, e_mis);
`endif
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_set(bit d, bit e, bit rq, bit rw, bit bc, bit b);
    e_done = d; e_err = e; e_req = rq; e_rfwe = rw;
    e_bchk = bc; e_busy = b; e_zero = 0; e_mis = 0;
  endtask

  task automatic quiet();
    start = 0;
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    exp_set(0, 0, 0, 0, 1, 0);
    cyc();
    mem_ack = 0;
  endtask

  task automatic run_txn(bit st, logic [2:0] f, logic [4:0] r,
                         logic [31:0] a, logic [31:0] sd, int dly,
                         int rst_at, logic [31:0] rdata);
    bit bad, mis;
    bad = illegal(st, f);
    mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = !bad && misal(f, a[1:0]);
`endif
    start = 1; is_store = st; funct3 = f; rd = r;
    addr = a; store_data = sd;
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    exp_set(0, 0, 0, 0, 1, 0);
    cyc();
    start = 0;
    mem_ack = 0;
    if (bad || mis) begin
      exp_set(1, 1, 0, 0, 0, 0);
      e_mis = mis;
      cyc();
      quiet();
      return;
    end
    for (int i = 0; ; i++) begin
      exp_set(0, 0, 1, 0, 1, 1);
      e_we = st;
      e_maddr = {a[31:2], 2'b00};
      e_be = st_be(f, a[1:0]);
      e_wdata = st_wd(f, sd);
      start = 1'($urandom);
      is_store = 1'($urandom);
      funct3 = 3'($urandom);
      addr = $urandom;
      rd = 5'($urandom);
      mem_ack = (i == dly);
      mem_rdata = (i == dly) ? rdata : $urandom;
      if (i == rst_at) begin
        rst = 1;
        cyc();
        rst = 0; start = 0; mem_ack = 0;
        exp_set(0, 0, 0, 0, 1, 0);
        e_zero = 1;
        cyc();
        quiet();
        return;
      end
      if (i == dly) begin
        cyc();
        start = 0;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
        exp_set(1, 0, 0, !st && r != 0, 0, 0);
        e_a3 = r;
        e_wd3 = ld_val(f, a[1:0], rdata);
        cyc();
        quiet();
        return;
      end
      if (i == TO - 1) begin
        cyc();
        start = 0;
        mem_ack = 0;
        exp_set(1, 1, 0, 0, 0, 0);
        cyc();
        quiet();
        return;
      end
      cyc();
    end
  endtask

  initial begin
    int dly, rat;
    bit st;
    logic [2:0] f;
    exp_set(0, 0, 0, 0, 1, 0);
    repeat (2) cyc();
    en = 1;
    exp_set(0, 0, 0, 0, 1, 0);
    e_zero = 1;
    cyc();
    rst = 0;
    quiet();

    run_txn(0, 3'b010, 5'd9, 32'h2004, 0, 0, -1, 32'hDEADBEEF);
    chk("lit_lw", cap_wd3, 32'hDEADBEEF);
    run_txn(0, 3'b000, 5'd3, 32'h0003, 0, 1, -1, 32'h80FF0102);
    chk("lit_lb", cap_wd3, 32'hFFFFFF80);
    run_txn(0, 3'b100, 5'd4, 32'h0003, 0, 2, -1, 32'h80FF0102);
    chk("lit_lbu", cap_wd3, 32'h00000080);
    run_txn(0, 3'b101, 5'd5, 32'h0002, 0, 0, -1, 32'h80FF0102);
    chk("lit_lhu", cap_wd3, 32'h000080FF);
    run_txn(1, 3'b000, 5'd0, 32'h0006, 32'h000000A5, 0, -1, 0);
    chk("lit_sb_be", cap_be, 4'b0100);
    chk("lit_sb_wd", cap_wdata, 32'hA5A5A5A5);
    reqcnt = 0;
    run_txn(1, 3'b010, 5'd0, 32'h100, 32'h1234, 99, -1, 0);
    chk("lit_timeout_req", reqcnt, 15);
    run_txn(0, 3'b010, 5'd0, 32'h40, 0, 1, -1, 32'h5555AAAA);
    run_txn(0, 3'b010, 5'd7, 32'h44, 0, 5, 2, 32'h1);
    run_txn(0, 3'b011, 5'd1, 32'h0, 0, 0, -1, 0);
    run_txn(1, 3'b100, 5'd1, 32'h0, 0, 0, -1, 0);
    run_txn(0, 3'b010, 5'd2, 32'h0002, 0, 0, -1, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom);
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = st ? 3'($urandom_range(0, 2))
                                            : 3'($urandom_range(0, 5));
      dly = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 5);
      rat = -1;
      if (dly > 0 && $urandom_range(0, 19) == 0)
        rat = $urandom_range(0, dly - 1);
      run_txn(st, f, 5'($urandom), $urandom, $urandom, dly, rat, $urandom);
    end

    en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
